// File: rtl/avalon_burst_slave_mem.sv
// -----------------------------------------------------------------------------
// avalon_burst_slave_mem
//   Avalon-MM burst-capable slave backed by a 2**ADDR_W x DATA_W memory.
//
//   Handshake: a command (avl_read or avl_write) is taken on a rising edge
//   when avl_waitrequest is 0. Write beats are strobed by avl_write and are
//   never stalled. A read burst raises avl_waitrequest for its whole duration
//   and returns one beat per cycle with avl_readdatavalid, starting the cycle
//   after the accept edge. Write wins when read and write arrive together.
//
// Ports
//   avl_clk, avl_rst_n       clock, asynchronous active-low reset
//   avl_address              word address of first beat (sampled at accept)
//   avl_read, avl_write      command strobes (avl_write also strobes beats)
//   avl_writedata            write data
//   avl_byteenable           per-byte write mask
//   avl_burstcount           beats in burst, 0 treated as 1 (sampled at accept)
//   avl_beginbursttransfer   informational, not used for acceptance
//   avl_readdata             read data, holds while avl_readdatavalid is 0
//   avl_readdatavalid        avl_readdata valid this cycle
//   avl_waitrequest          1 while a read burst is being returned
//   dbg_state                FSM state: 0 IDLE, 1 WR_BURST, 2 RD_BURST
// -----------------------------------------------------------------------------
module avalon_burst_slave_mem #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 10,
    parameter int BURST_W = 10
) (
    input  logic                  avl_clk,
    input  logic                  avl_rst_n,
    input  logic [ADDR_W-1:0]     avl_address,
    input  logic                  avl_read,
    input  logic                  avl_write,
    input  logic [DATA_W-1:0]     avl_writedata,
    input  logic [DATA_W/8-1:0]   avl_byteenable,
    input  logic [BURST_W-1:0]    avl_burstcount,
    input  logic                  avl_beginbursttransfer,
    output logic [DATA_W-1:0]     avl_readdata,
    output logic                  avl_readdatavalid,
    output logic                  avl_waitrequest,
    output logic [1:0]            dbg_state
);

    localparam int NBYTES = DATA_W / 8;
    localparam logic [ADDR_W-1:0]  ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [BURST_W-1:0] BURST_ONE = {{(BURST_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_BURST = 2'd2
    } state_t;

    state_t               state;
    logic [ADDR_W-1:0]    addr_q;      // address of the next beat
    logic [BURST_W-1:0]   beats_left;  // beats still to go after the current one
    logic [BURST_W-1:0]   n_beats;
    logic                 wr_en;
    logic [ADDR_W-1:0]    wr_addr;

    logic [DATA_W-1:0]    mem [2**ADDR_W];

    // The begin-burst marker carries no information this slave needs.
    logic unused_bbt;
    assign unused_bbt = avl_beginbursttransfer;

    assign n_beats   = (avl_burstcount == '0) ? BURST_ONE : avl_burstcount;
    assign dbg_state = state;

    // Write port select. Gated by reset so nothing lands in memory while
    // reset is held, even though the FSM sits in IDLE during reset.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = addr_q;
        if (avl_rst_n) begin
            case (state)
                IDLE: begin
                    if (avl_write) begin
                        wr_en   = 1'b1;
                        wr_addr = avl_address;
                    end
                end
                WR_BURST: begin
                    if (avl_write) begin
                        wr_en   = 1'b1;
                        wr_addr = addr_q;
                    end
                end
                default: begin
                    wr_en = 1'b0;
                end
            endcase
        end
    end

    // Memory contents survive reset, so this block has no reset.
    always_ff @(posedge avl_clk) begin
        if (wr_en) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (avl_byteenable[b]) begin
                    mem[wr_addr][b*8 +: 8] <= avl_writedata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge avl_clk or negedge avl_rst_n) begin
        if (!avl_rst_n) begin
            state             <= IDLE;
            addr_q            <= '0;
            beats_left        <= '0;
            avl_readdata      <= '0;
            avl_readdatavalid <= 1'b0;
            avl_waitrequest   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    avl_readdatavalid <= 1'b0;
                    avl_waitrequest   <= 1'b0;
                    if (avl_write) begin
                        // Beat 0 is written this edge by the memory block.
                        addr_q     <= avl_address + ADDR_ONE;
                        beats_left <= n_beats - BURST_ONE;
                        if (n_beats > BURST_ONE) begin
                            state <= WR_BURST;
                        end
                    end else if (avl_read) begin
                        // Beat 0 is registered now and shows next cycle.
                        avl_readdata      <= mem[avl_address];
                        avl_readdatavalid <= 1'b1;
                        avl_waitrequest   <= 1'b1;
                        addr_q            <= avl_address + ADDR_ONE;
                        beats_left        <= n_beats - BURST_ONE;
                        state             <= RD_BURST;
                    end
                end
                WR_BURST: begin
                    // Cycles without avl_write are idle and consume no beat.
                    if (avl_write) begin
                        addr_q     <= addr_q + ADDR_ONE;
                        beats_left <= beats_left - BURST_ONE;
                        if (beats_left == BURST_ONE) begin
                            state <= IDLE;
                        end
                    end
                end
                RD_BURST: begin
                    if (beats_left == '0) begin
                        // Last beat was on the bus this cycle; readdata holds.
                        avl_readdatavalid <= 1'b0;
                        avl_waitrequest   <= 1'b0;
                        state             <= IDLE;
                    end else begin
                        avl_readdata <= mem[addr_q];
                        addr_q       <= addr_q + ADDR_ONE;
                        beats_left   <= beats_left - BURST_ONE;
                    end
                end
                default: begin
                    state             <= IDLE;
                    avl_readdatavalid <= 1'b0;
                    avl_waitrequest   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_burst_slave_mem.sv
// -----------------------------------------------------------------------------
// tb_avalon_burst_slave_mem
//   Directed bench for avalon_burst_slave_mem (DATA_W=16, ADDR_W=10).
//   Inputs are driven 1 ns after the rising edge; outputs are sampled there
//   too, before the next drive. Expected read data comes from exp_q.
// -----------------------------------------------------------------------------
module tb_avalon_burst_slave_mem;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 10;
    localparam int BURST_W = 10;

    logic                  avl_clk;
    logic                  avl_rst_n;
    logic [ADDR_W-1:0]     avl_address;
    logic                  avl_read;
    logic                  avl_write;
    logic [DATA_W-1:0]     avl_writedata;
    logic [DATA_W/8-1:0]   avl_byteenable;
    logic [BURST_W-1:0]    avl_burstcount;
    logic                  avl_beginbursttransfer;
    logic [DATA_W-1:0]     avl_readdata;
    logic                  avl_readdatavalid;
    logic                  avl_waitrequest;
    logic [1:0]            dbg_state;

    logic [DATA_W-1:0]     exp_q[$];
    int                    n_checks = 0;
    int                    n_pass   = 0;

    avalon_burst_slave_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BURST_W(BURST_W)
    ) dut (
        .avl_clk               (avl_clk),
        .avl_rst_n             (avl_rst_n),
        .avl_address           (avl_address),
        .avl_read              (avl_read),
        .avl_write             (avl_write),
        .avl_writedata         (avl_writedata),
        .avl_byteenable        (avl_byteenable),
        .avl_burstcount        (avl_burstcount),
        .avl_beginbursttransfer(avl_beginbursttransfer),
        .avl_readdata          (avl_readdata),
        .avl_readdatavalid     (avl_readdatavalid),
        .avl_waitrequest       (avl_waitrequest),
        .dbg_state             (dbg_state)
    );

    // ---------------- clock ----------------
    initial avl_clk = 1'b0;
    always #5 avl_clk = ~avl_clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge avl_clk);
        #1;
    endtask

    // ---------------- drivers ----------------
    // One write beat; bc/addr only matter on the accepting beat.
    task automatic wr_beat(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                           input logic [1:0] be, input logic [BURST_W-1:0] bc);
        check("wr_waitreq", {31'd0, avl_waitrequest}, 32'd0);
        avl_write      = 1'b1;
        avl_address    = addr;
        avl_writedata  = data;
        avl_byteenable = be;
        avl_burstcount = bc;
        tick();
        avl_write      = 1'b0;
    endtask

    // Read burst; every beat is compared against the head of exp_q.
    task automatic rd_burst(input logic [ADDR_W-1:0] addr, input int n);
        int nb;
        logic [DATA_W-1:0] last;
        nb   = (n == 0) ? 1 : n;
        last = '0;
        check("rd_pre_waitreq", {31'd0, avl_waitrequest}, 32'd0);
        avl_read       = 1'b1;
        avl_address    = addr;
        avl_burstcount = BURST_W'(n);
        tick();
        avl_read = 1'b0;
        for (int k = 0; k < nb; k++) begin
            if (exp_q.size() == 0) begin
                check("rd_exp_q_empty", 32'd1, 32'd0);
            end else begin
                last = exp_q.pop_front();
                check("rd_valid",   {31'd0, avl_readdatavalid}, 32'd1);
                check("rd_waitreq", {31'd0, avl_waitrequest},   32'd1);
                check("rd_data",    {16'd0, avl_readdata},      {16'd0, last});
            end
            tick();
        end
        check("rd_end_valid",   {31'd0, avl_readdatavalid}, 32'd0);
        check("rd_end_waitreq", {31'd0, avl_waitrequest},   32'd0);
        check("rd_end_state",   {30'd0, dbg_state},         32'd0);
        check("rd_hold_data",   {16'd0, avl_readdata},      {16'd0, last});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        avl_rst_n              = 1'b0;
        avl_address            = '0;
        avl_read               = 1'b0;
        avl_write              = 1'b0;
        avl_writedata          = '0;
        avl_byteenable         = '0;
        avl_burstcount         = '0;
        avl_beginbursttransfer = 1'b0;

        #1;
        check("rst_valid",   {31'd0, avl_readdatavalid}, 32'd0);
        check("rst_waitreq", {31'd0, avl_waitrequest},   32'd0);
        check("rst_data",    {16'd0, avl_readdata},      32'd0);
        check("rst_state",   {30'd0, dbg_state},         32'd0);
        repeat (3) tick();
        avl_rst_n = 1'b1;
        tick();

        // Single writes of 0x07 to 0..3 (burstcount 0), single reads of 0 and 1.
        for (int a = 0; a < 4; a++) wr_beat(ADDR_W'(a), 16'h0007, 2'b11, '0);
        check("single_wr_state", {30'd0, dbg_state}, 32'd0);
        exp_q.push_back(16'h0007);
        rd_burst(10'd0, 0);
        exp_q.push_back(16'h0007);
        rd_burst(10'd1, 0);

        // Burst write N=4 at 0 with avl_write held, then burst read N=4.
        avl_beginbursttransfer = 1'b1;
        wr_beat(10'd0, 16'd1, 2'b11, 10'd4);
        avl_beginbursttransfer = 1'b0;
        check("wrb_state", {30'd0, dbg_state}, 32'd1);
        wr_beat(10'd0, 16'd2, 2'b11, 10'd4);
        wr_beat(10'd0, 16'd3, 2'b11, 10'd4);
        wr_beat(10'd0, 16'd4, 2'b11, 10'd4);
        check("wrb_done_state", {30'd0, dbg_state}, 32'd0);
        for (int v = 1; v <= 4; v++) exp_q.push_back(DATA_W'(v));
        rd_burst(10'd0, 4);

        // Clear 0..3, then burst write with an idle cycle between beats 1 and 2.
        // A read during that idle cycle must be ignored.
        for (int a = 0; a < 4; a++) wr_beat(ADDR_W'(a), 16'h0000, 2'b11, '0);
        wr_beat(10'd0, 16'd1, 2'b11, 10'd4);
        wr_beat(10'd0, 16'd2, 2'b11, 10'd4);
        avl_read      = 1'b1;
        avl_writedata = 16'h00EE;
        tick();
        avl_read = 1'b0;
        check("gap_valid",   {31'd0, avl_readdatavalid}, 32'd0);
        check("gap_waitreq", {31'd0, avl_waitrequest},   32'd0);
        check("gap_state",   {30'd0, dbg_state},         32'd1);
        wr_beat(10'd0, 16'd3, 2'b11, 10'd4);
        wr_beat(10'd0, 16'd4, 2'b11, 10'd4);
        for (int v = 1; v <= 4; v++) exp_q.push_back(DATA_W'(v));
        rd_burst(10'd0, 4);

        // Byte enables: 0xABCD, then low byte only 0x0012 -> 0xAB12; all-zero mask writes nothing.
        wr_beat(10'd5, 16'hABCD, 2'b11, '0);
        wr_beat(10'd5, 16'h0012, 2'b01, '0);
        exp_q.push_back(16'hAB12);
        rd_burst(10'd5, 1);
        wr_beat(10'd5, 16'hFFFF, 2'b00, '0);
        exp_q.push_back(16'hAB12);
        rd_burst(10'd5, 1);

        // Read and write together in IDLE: the write wins, no read data follows.
        avl_read = 1'b1;
        wr_beat(10'd8, 16'h005A, 2'b11, '0);
        avl_read = 1'b0;
        check("rw_valid",   {31'd0, avl_readdatavalid}, 32'd0);
        check("rw_waitreq", {31'd0, avl_waitrequest},   32'd0);
        exp_q.push_back(16'h005A);
        rd_burst(10'd8, 1);

        // Reset after beat 1 of a 4-beat read burst.
        avl_read       = 1'b1;
        avl_address    = 10'd0;
        avl_burstcount = 10'd4;
        tick();
        avl_read = 1'b0;
        check("rstmid_b0", {16'd0, avl_readdata}, 32'd1);
        tick();
        check("rstmid_b1", {16'd0, avl_readdata}, 32'd2);
        #2;
        avl_rst_n = 1'b0;
        #1;
        check("rstmid_valid",   {31'd0, avl_readdatavalid}, 32'd0);
        check("rstmid_waitreq", {31'd0, avl_waitrequest},   32'd0);
        check("rstmid_state",   {30'd0, dbg_state},         32'd0);
        check("rstmid_data",    {16'd0, avl_readdata},      32'd0);
        tick();
        check("rstmid_hold_valid", {31'd0, avl_readdatavalid}, 32'd0);
        avl_rst_n = 1'b1;
        tick();
        exp_q.push_back(16'd1);
        rd_burst(10'd0, 1);
        exp_q.push_back(16'd3);
        exp_q.push_back(16'd4);
        rd_burst(10'd2, 2);

        // Address wrap: burst write N=3 at 1023 lands at 1023, 0, 1.
        wr_beat(10'd1023, 16'h0011, 2'b11, 10'd3);
        wr_beat(10'd0,    16'h0022, 2'b11, 10'd3);
        wr_beat(10'd0,    16'h0033, 2'b11, 10'd3);
        exp_q.push_back(16'h0011);
        exp_q.push_back(16'h0022);
        exp_q.push_back(16'h0033);
        rd_burst(10'd1023, 3);
        exp_q.push_back(16'h0022);
        exp_q.push_back(16'h0033);
        exp_q.push_back(16'd3);
        rd_burst(10'd0, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
